// File: rtl/ssd_scan_driver.sv
// N-digit seven-segment scan driver: frame-synchronous shadow capture, leading-zero
// suppression, per-digit blank/dot control and PWM brightness; all outputs registered.
module ssd_scan_driver #(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned SCAN_BITS = 18,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic                    board_clk,
  input  logic                    Reset,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_in,
  input  logic                    lz_suppress,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [N_DIGITS-1:0]     An,
  output logic [7:0]              Cath,
  output logic [2:0]              digit_idx,
  output logic                    frame_tick
);

  localparam int unsigned DIG_W = 4 * N_DIGITS;

  logic [SCAN_BITS-1:0] prescaler;
  logic [DIG_W-1:0]     sh_digits;
  logic [N_DIGITS-1:0]  sh_dp;
  logic [N_DIGITS-1:0]  sh_blank;
  logic                 sh_lz;
  logic [PWM_BITS-1:0]  sh_bri;

  logic                 slot_end_c;
  logic                 last_slot_c;
  logic                 frame_end_c;
  logic [PWM_BITS-1:0]  pwm_field_c;

  logic [3:0]           nib_c;
  logic                 dp_bit_c;
  logic                 blank_bit_c;
  logic                 supp_c;
  logic                 zero_run_c;
  logic                 lit_c;
  logic [N_DIGITS-1:0]  an_sel_c;
  logic [N_DIGITS-1:0]  an_next_c;
  logic [7:0]           cath_next_c;

  // Active-low abcdefg pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign slot_end_c  = &prescaler;
  assign last_slot_c = (digit_idx == 3'(N_DIGITS - 1));
  assign frame_end_c = slot_end_c && last_slot_c;
  assign pwm_field_c = prescaler[SCAN_BITS-1 -: PWM_BITS];

  // Slot decode from shadow state; zero_run tracks "all digits left of and including i are 0"
  always_comb begin
    nib_c       = 4'h0;
    dp_bit_c    = 1'b0;
    blank_bit_c = 1'b1;
    supp_c      = 1'b0;
    zero_run_c  = 1'b1;
    an_sel_c    = '1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      zero_run_c = zero_run_c && (sh_digits[4*(N_DIGITS-1-i) +: 4] == 4'h0);
      if (digit_idx == 3'(i)) begin
        nib_c                   = sh_digits[4*(N_DIGITS-1-i) +: 4];
        dp_bit_c                = sh_dp[N_DIGITS-1-i];
        blank_bit_c             = sh_blank[N_DIGITS-1-i];
        supp_c                  = sh_lz && zero_run_c && (i < N_DIGITS - 1);
        an_sel_c[N_DIGITS-1-i]  = 1'b0;
      end
    end

    lit_c = !blank_bit_c && (pwm_field_c < sh_bri) && !(supp_c && !dp_bit_c);

    an_next_c   = '1;
    cath_next_c = 8'hFF;
    if (lit_c) begin
      an_next_c   = an_sel_c;
      cath_next_c = {(supp_c ? 7'h7F : hex7(nib_c)), ~dp_bit_c};
    end
  end

  // Scan counters, frame-end capture and registered pin drive
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      prescaler  <= '0;
      digit_idx  <= 3'd0;
      frame_tick <= 1'b0;
      An         <= '1;
      Cath       <= 8'hFF;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '1;
      sh_lz      <= 1'b0;
      sh_bri     <= '0;
    end else begin
      prescaler  <= prescaler + SCAN_BITS'(1);
      if (slot_end_c) begin
        digit_idx <= last_slot_c ? 3'd0 : digit_idx + 3'd1;
      end
      frame_tick <= frame_end_c;
      if (frame_end_c) begin
        sh_digits <= digits_in;
        sh_dp     <= dp_in;
        sh_blank  <= blank_in;
        sh_lz     <= lz_suppress;
        sh_bri    <= brightness;
      end
      An   <= an_next_c;
      Cath <= cath_next_c;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver (4 digits, 16-cycle slots, 64-cycle frames): directed
// scenarios plus random frames, every cycle compared against an arithmetic display model.
module tb_ssd_scan_driver;

  logic        board_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [15:0] digits_in = 16'h12AF;
  logic [3:0]  dp_in     = 4'b0000;
  logic [3:0]  blank_in  = 4'b0000;
  logic        lz_suppress = 1'b0;
  logic [1:0]  brightness  = 2'd3;
  logic [3:0]  An;
  logic [7:0]  Cath;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // cycles since reset release, and the model's view of the captured frame data
  int          k = 0;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_blk;
  logic        s_lz;
  logic [1:0]  s_bri;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  ssd_scan_driver #(.N_DIGITS(4), .SCAN_BITS(4), .PWM_BITS(2)) dut (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .An          (An),
    .Cath        (Cath),
    .digit_idx   (digit_idx),
    .frame_tick  (frame_tick)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at k=%0d: observed %h, expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    s_dig = 16'h0; s_dp = 4'h0; s_blk = 4'hF; s_lz = 1'b0; s_bri = 2'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_an"},   32'(An),         32'hF);
    chk({tag, "_cath"}, 32'(Cath),       32'hFF);
    chk({tag, "_idx"},  32'(digit_idx),  32'h0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  // One clock: predict outputs from the display state of cycle k, then compare after the edge
  task automatic tick();
    int pre, slot, pwm, sh;
    logic [3:0] d;
    logic dpb, blk, supp, lit;
    logic [3:0] exp_an;
    logic [7:0] exp_cath;
    pre  = k % 16;
    slot = (k / 16) % 4;
    pwm  = pre / 4;
    sh   = 4 * (3 - slot);
    d    = 4'((s_dig >> sh) & 16'hF);
    dpb  = s_dp[3-slot];
    blk  = s_blk[3-slot];
    supp = s_lz && (slot < 3) && ((s_dig >> sh) == 16'h0);
    lit  = !blk && (pwm < int'(s_bri)) && !(supp && !dpb);
    exp_an   = lit ? 4'(~(32'd1 << (3 - slot))) : 4'hF;
    exp_cath = lit ? {(supp ? 7'h7F : seg_tab[d]), ~dpb} : 8'hFF;
    @(posedge board_clk);
    #1;
    chk("an",   32'(An),         32'(exp_an));
    chk("cath", 32'(Cath),       32'(exp_cath));
    chk("idx",  32'(digit_idx),  32'(((k + 1) / 16) % 4));
    chk("tick", 32'(frame_tick), 32'((k % 64) == 63));
    if ((k % 64) == 63) begin
      s_dig = digits_in; s_dp = dp_in; s_blk = blank_in; s_lz = lz_suppress; s_bri = brightness;
    end
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                        input logic lz, input logic [1:0] br);
    digits_in = d; dp_in = dp; blank_in = bl; lz_suppress = lz; brightness = br;
  endtask

  initial begin
    model_reset();
    // Reset held with 12AF presented
    for (int i = 0; i < 3; i++) begin
      @(posedge board_clk);
      #1;
      chk_reset_vals("rst_hold");
    end
    @(negedge board_clk);
    Reset = 1'b0;
    k = 0;

    // first frame dark, then 12AF scanned
    run(64);
    run(64);
    // leading-zero suppression
    set_in(16'h0030, 4'b0000, 4'b0000, 1'b1, 2'd3);
    run(128);
    set_in(16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3);
    run(128);
    set_in(16'h0000, 4'b1000, 4'b0000, 1'b1, 2'd3);
    run(128);
    // tear-free: change mid-frame at cycle 20
    set_in(16'h12AF, 4'b0000, 4'b0000, 1'b0, 2'd3);
    run(64);
    run(20);
    digits_in = 16'h5555;
    run(44);
    run(64);
    // brightness 0, then blank overriding dp
    brightness = 2'd0;
    run(128);
    set_in(16'h89CD, 4'b0010, 4'b0010, 1'b0, 2'd3);
    run(128);
    set_in(16'h4BE6, 4'b0101, 4'b0000, 1'b0, 2'd1);
    run(128);

    // random frames with random mid-frame changes
    for (int f = 0; f < 8; f++) begin
      int cut;
      set_in(16'($urandom), 4'($urandom),
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
             1'($urandom), 2'($urandom));
      if ($urandom_range(0, 1) == 1) digits_in = digits_in & 16'h00FF;
      cut = int'($urandom_range(1, 63));
      run(cut);
      digits_in = 16'($urandom);
      run(64 - cut);
    end

    // mid-frame reset at cycle 37: outputs clear without a clock edge
    set_in(16'h7E1D, 4'b0001, 4'b0000, 1'b0, 2'd3);
    run(64 + 64 - (k % 64) + 37);
    #1;
    Reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge board_clk);
      #1;
      chk_reset_vals("rst_hold2");
    end
    @(negedge board_clk);
    Reset = 1'b0;
    k = 0;
    run(128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
